ama_riscv_load_unit: RTL and testbench

Load-side counterpart to the DMEM store byte-mask logic: captures a load request (byte offset, funct3 width) in the MEM stage, then aligns and sign- or zero-extends the synchronous-read DMEM word that returns one cycle later. A small FSM holds the aligned result across pipeline stalls so writeback sees stable data. Sits between the DMEM read port and the writeback mux. It uses the same offset and width encodings and the same misalignment rules as the store path.

---
 rtl/ama_riscv_load_unit.sv | 133 +++++++++++++
 tb/tb_ama_riscv_load_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_load_unit.sv
// Load unit: captures a load request in MEM and aligns/extends the DMEM word
// that returns one cycle later. The result is held stable across pipeline stalls.
module ama_riscv_load_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  width_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        load_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  req_offset_q, req_offset_d;
  logic [2:0]  req_width_q, req_width_d;
  logic        req_err_q, req_err_d;
  logic [31:0] hold_data_q, hold_data_d;

  logic        accept;
  logic        err_in;
  logic [31:0] src;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;
  logic [31:0] ext;

  // flush and stall both override a new request
  assign accept = en_i && !stall_i && !flush_i;

  // Misalignment / unsupported-width check on the incoming request
  always_comb begin
    err_in = 1'b0;
    if (width_i[1:0] == 2'b11)                         err_in = 1'b1;
    if (width_i[2] && (width_i[1:0] == 2'b10))         err_in = 1'b1;
    if ((width_i[1:0] == 2'b01) && (offset_i == 2'd3)) err_in = 1'b1;
    if ((width_i[1:0] == 2'b10) && (offset_i != 2'd0)) err_in = 1'b1;
  end

  // State, request and hold registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_offset_q <= 2'd0;
      req_width_q  <= 3'd0;
      req_err_q    <= 1'b0;
      hold_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_offset_q <= req_offset_d;
      req_width_q  <= req_width_d;
      req_err_q    <= req_err_d;
      hold_data_q  <= hold_data_d;
    end
  end

  // Next-state: flush > stall > accept; hold_data only snapshots on PEND->HOLD
  always_comb begin
    state_d      = state_q;
    req_offset_d = req_offset_q;
    req_width_d  = req_width_q;
    req_err_d    = req_err_q;
    hold_data_d  = hold_data_q;
    case (state_q)
      IDLE: if (accept) state_d = PEND;
      PEND: begin
        if (flush_i)      state_d = IDLE;
        else if (stall_i) begin
          state_d     = HOLD;
          hold_data_d = dmem_rdata_i;
        end
        else if (accept)  state_d = PEND;
        else              state_d = IDLE;
      end
      HOLD: begin
        if (flush_i)      state_d = IDLE;
        else if (stall_i) state_d = HOLD;
        else if (accept)  state_d = PEND;
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      req_offset_d = offset_i;
      req_width_d  = width_i;
      req_err_d    = err_in;
    end
  end

  // Align and extend from live DMEM data or the held snapshot
  always_comb begin
    src = (state_q == HOLD) ? hold_data_q : dmem_rdata_i;
    case (req_offset_q)
      2'd0:    byte_sel = src[7:0];
      2'd1:    byte_sel = src[15:8];
      2'd2:    byte_sel = src[23:16];
      default: byte_sel = src[31:24];
    endcase
    case (req_offset_q)
      2'd0:    half_sel = src[15:0];
      2'd1:    half_sel = src[23:8];
      default: half_sel = src[31:16];  // offset 3 is flagged as an error
    endcase
    sgn = ~req_width_q[2];
    case (req_width_q[1:0])
      2'b00:   ext = {{24{sgn & byte_sel[7]}}, byte_sel};
      2'b01:   ext = {{16{sgn & half_sel[15]}}, half_sel};
      default: ext = src;
    endcase
  end

  // Outputs: valid in PEND/HOLD; an erroring request returns zero data
  always_comb begin
    load_data_o  = 32'd0;
    load_valid_o = 1'b0;
    load_err_o   = 1'b0;
    if ((state_q == PEND) || (state_q == HOLD)) begin
      load_valid_o = 1'b1;
      if (req_err_q) load_err_o  = 1'b1;
      else           load_data_o = ext;
    end
  end

endmodule

// File: tb/tb_ama_riscv_load_unit.sv
// Bench: directed per-cycle vector table, then randomized traffic against a
// behavioural model of the load unit.
module tb_ama_riscv_load_unit;

  logic        clk;
  logic        rst, en, stall, flush;
  logic [1:0]  offset;
  logic [2:0]  width;
  logic [31:0] dmem;
  logic [31:0] load_data;
  logic        load_valid, load_err;

  int checks = 0;
  int errors = 0;

  ama_riscv_load_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .offset_i     (offset),
    .width_i      (width),
    .stall_i      (stall),
    .flush_i      (flush),
    .dmem_rdata_i (dmem),
    .load_data_o  (load_data),
    .load_valid_o (load_valid),
    .load_err_o   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d;
  } out_t;

  typedef struct {
    logic        en, stall, flush, rst;
    logic [1:0]  off;
    logic [2:0]  w;
    logic [31:0] dmem;
    logic        chk;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: is a result live, and is it frozen by a stall
  logic       m_live = 1'b0;
  logic       m_frozen = 1'b0;
  out_t       m_fout;
  logic [1:0] m_off = 2'd0;
  logic [2:0] m_w = 3'd0;

  function automatic out_t ref_load(input logic [31:0] word, input logic [1:0] off,
                                    input logic [2:0] w);
    out_t r;
    longint unsigned nbytes, shifted, mask, val;
    int sz;
    sz = int'(w[1:0]);
    r.v = 1'b1;
    r.e = (sz == 3) || (w[2] && sz == 2) || (sz == 1 && off == 2'd3) || (sz == 2 && off != 2'd0);
    r.d = 32'd0;
    if (!r.e) begin
      nbytes  = longint'(1) << sz;
      shifted = longint'(word) >> (8 * int'(off));
      mask    = (longint'(1) << (8 * nbytes)) - 1;
      val     = shifted & mask;
      if (!w[2] && val >= (longint'(1) << (8 * nbytes - 1)))
        val = val + (longint'(1) << 32) - (longint'(1) << (8 * nbytes));
      r.d = val[31:0];
    end
    return r;
  endfunction

  function automatic out_t model_out(input logic [31:0] word);
    out_t r;
    r.v = 1'b0; r.e = 1'b0; r.d = 32'd0;
    if (m_live) r = m_frozen ? m_fout : ref_load(word, m_off, m_w);
    return r;
  endfunction

  task automatic compare(input string name, input out_t exp);
    checks++;
    if (load_valid !== exp.v || load_err !== exp.e || load_data !== exp.d) begin
      errors++;
      $display("FAIL %s t=%0t got v=%0b e=%0b d=%08h want v=%0b e=%0b d=%08h",
               name, $time, load_valid, load_err, load_data, exp.v, exp.e, exp.d);
    end
  endtask

  // One clock cycle: drive, compare mid-cycle, advance model at the edge
  task automatic cycle(input vec_t t, input logic use_table, input string name);
    out_t cur;
    en = t.en; offset = t.off; width = t.w; stall = t.stall;
    flush = t.flush; rst = t.rst; dmem = t.dmem;
    #4;
    cur = model_out(dmem);
    if (use_table) begin
      if (t.chk) compare(name, t.exp);
    end else begin
      compare(name, cur);
    end
    @(posedge clk);
    if (rst) begin
      m_live = 1'b0; m_frozen = 1'b0;
    end else if (flush) begin
      m_live = 1'b0; m_frozen = 1'b0;
    end else if (stall) begin
      if (m_live && !m_frozen) begin
        m_frozen = 1'b1; m_fout = cur;
      end
    end else if (en) begin
      m_live = 1'b1; m_frozen = 1'b0; m_off = offset; m_w = width;
    end else begin
      m_live = 1'b0; m_frozen = 1'b0;
    end
    #1;
  endtask

  task automatic add(input logic en_, input logic [1:0] off_, input logic [2:0] w_,
                     input logic st_, input logic fl_, input logic rs_,
                     input logic [31:0] dm_, input logic chk_,
                     input logic v_, input logic e_, input logic [31:0] d_);
    vec_t t;
    t.en = en_; t.off = off_; t.w = w_; t.stall = st_; t.flush = fl_; t.rst = rs_;
    t.dmem = dm_; t.chk = chk_; t.exp.v = v_; t.exp.e = e_; t.exp.d = d_;
    vecs.push_back(t);
  endtask

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  initial begin
    m_fout.v = 1'b0; m_fout.e = 1'b0; m_fout.d = 32'd0;
    //   en off w    st fl rs dmem          chk v e data
    add(0, 0, LB,  0, 0, 1, 32'h0,        0, 0, 0, 32'h0);          // reset
    add(0, 0, LB,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);          // reset state
    add(1, 2, LB,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);          // LB off2, no comb path
    add(1, 2, LBU, 0, 0, 0, 32'h1280FF34, 1, 1, 0, 32'hFFFFFF80);
    add(0, 0, LB,  0, 0, 0, 32'h1280FF34, 1, 1, 0, 32'h00000080);
    add(0, 0, LB,  0, 0, 0, 32'h1280FF34, 1, 0, 0, 32'h0);
    add(1, 1, LH,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);
    add(1, 1, LHU, 0, 0, 0, 32'hAB8001CD, 1, 1, 0, 32'hFFFF8001);
    add(1, 0, LW,  0, 0, 0, 32'hAB8001CD, 1, 1, 0, 32'h00008001);
    add(0, 0, LB,  0, 0, 0, 32'hAB8001CD, 1, 1, 0, 32'hAB8001CD);
    add(1, 2, LW,  0, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0);          // misaligned LW
    add(1, 3, LH,  0, 0, 0, 32'hFFFFFFFF, 1, 1, 1, 32'h0);
    add(1, 0, 3'b011, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 1, 32'h0);
    add(0, 0, LB,  0, 0, 0, 32'hFFFFFFFF, 1, 1, 1, 32'h0);
    add(0, 0, LB,  0, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0);
    add(1, 0, LB,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);          // stall hold
    add(0, 0, LB,  1, 0, 0, 32'h000000F0, 1, 1, 0, 32'hFFFFFFF0);
    add(0, 0, LB,  1, 0, 0, 32'h0,        1, 1, 0, 32'hFFFFFFF0);
    add(0, 0, LB,  1, 0, 0, 32'h0,        1, 1, 0, 32'hFFFFFFF0);
    add(0, 0, LB,  0, 0, 0, 32'h0,        1, 1, 0, 32'hFFFFFFF0);
    add(0, 0, LB,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);
    add(1, 0, LW,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);          // back-to-back
    add(1, 3, LBU, 0, 0, 0, 32'h11223344, 1, 1, 0, 32'h11223344);
    add(1, 2, LH,  0, 0, 0, 32'hA5000000, 1, 1, 0, 32'h000000A5);
    add(0, 0, LB,  0, 0, 0, 32'h87650000, 1, 1, 0, 32'hFFFF8765);
    add(0, 0, LB,  0, 0, 0, 32'h87650000, 1, 0, 0, 32'h0);
    add(1, 0, LW,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);          // flush in PEND
    add(0, 0, LB,  0, 1, 0, 32'h12345678, 1, 1, 0, 32'h12345678);
    add(1, 0, LW,  0, 0, 0, 32'h12345678, 1, 0, 0, 32'h0);
    add(0, 0, LB,  0, 0, 0, 32'hDEADBEEF, 1, 1, 0, 32'hDEADBEEF);
    add(1, 0, LW,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);          // flush in HOLD
    add(0, 0, LB,  1, 0, 0, 32'h00000001, 1, 1, 0, 32'h00000001);
    add(0, 0, LB,  1, 1, 0, 32'h00000002, 1, 1, 0, 32'h00000001);
    add(1, 0, LW,  0, 0, 0, 32'h00000002, 1, 0, 0, 32'h0);
    add(0, 0, LB,  0, 0, 0, 32'h0BADF00D, 1, 1, 0, 32'h0BADF00D);
    add(1, 0, LW,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0);          // rst in HOLD
    add(0, 0, LB,  1, 0, 0, 32'h00000003, 1, 1, 0, 32'h00000003);
    add(0, 0, LB,  1, 0, 1, 32'h00000004, 1, 1, 0, 32'h00000003);
    add(1, 0, LW,  0, 0, 0, 32'h00000004, 1, 0, 0, 32'h0);
    add(0, 0, LB,  0, 0, 0, 32'hCAFEF00D, 1, 1, 0, 32'hCAFEF00D);
    add(1, 0, LW,  0, 1, 0, 32'h0,        1, 0, 0, 32'h0);          // flush rejects en
    add(1, 0, LW,  1, 0, 0, 32'h55555555, 1, 0, 0, 32'h0);          // stall ignores en
    add(0, 0, LB,  0, 0, 0, 32'h55555555, 1, 0, 0, 32'h0);

    foreach (vecs[i]) cycle(vecs[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      vec_t t;
      t.en    = ($urandom_range(99) < 60);
      t.stall = ($urandom_range(99) < 25);
      t.flush = ($urandom_range(99) < 8);
      t.rst   = ($urandom_range(99) < 3);
      t.off   = 2'($urandom_range(3));
      t.w     = 3'($urandom_range(7));
      t.dmem  = $urandom;
      t.chk   = 1'b1;
      t.exp.v = 1'b0; t.exp.e = 1'b0; t.exp.d = 32'd0;
      cycle(t, 1'b0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
